// File: rtl/ctrl_exec_pipe.sv
// ctrl_exec_pipe: branch-lane control-transfer execute unit.
// Resolves jumps and conditional branches (direction, next PC, link value,
// mispredict) and carries the op tag through a fixed-latency elastic pipeline
// of STAGES register stages with valid/ready handshakes and a flush input.
// Optional feature: define CTRL_PERF_CNT_EN to add the saturating
// brCount_o / mispredCount_o performance counters.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif

module ctrl_exec_pipe #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int IMM_W    = 16,
  parameter int TARGET_W = 26,
  parameter int TAG_W    = 7,
  parameter int STAGES   = 2,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DATA_W-1:0]          data1_i,
  input  logic [DATA_W-1:0]          data2_i,
  input  logic [IMM_W-1:0]           immd_i,
  input  logic [`SIZE_OPCODE_I-1:0]  opcode_i,
  input  logic [PC_W-1:0]            predictedTarget_i,
  input  logic                       predictedDir_i,
  input  logic [PC_W-1:0]            pc_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic [TAG_W-1:0]           tag_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [PC_W-1:0]            result_o,
  output logic [PC_W-1:0]            nextPC_o,
  output logic                       direction_o,
  output logic [7:0]                 flags_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           brCount_o,
  output logic [CNT_W-1:0]           mispredCount_o
`endif
);

  localparam int OPW = `SIZE_OPCODE_I;

  // Opcode encodings of the control-transfer ops handled by this lane
  localparam logic [OPW-1:0] OP_JUMP = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_JR   = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_JALR = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_BLEZ = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_BGTZ = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_BLTZ = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_BGEZ = OPW'(8'h0A);
  localparam logic [OPW-1:0] OP_BC1F = OPW'(8'h0B);
  localparam logic [OPW-1:0] OP_BC1T = OPW'(8'h0C);

  // Flag bit positions
  localparam int FL_CTRL = 7;
  localparam int FL_REGS = 5;
  localparam int FL_LINK = 3;
  localparam int FL_EXEC = 2;
  localparam int FL_EXC  = 1;
  localparam int FL_MISP = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  result;
    logic [PC_W-1:0]  next_pc;
    logic             direction;
    logic [7:0]       flags;
  } op_t;

  // Branch target: link + sign-extended word offset, wrapping modulo 2^PC_W
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0]  link,
                                                    input logic [IMM_W-1:0] imm);
    logic signed [IMM_W+1:0]  imm_bytes;
    logic signed [DATA_W-1:0] imm_sext;
    imm_bytes = {imm, 2'b00};
    imm_sext  = DATA_W'(imm_bytes);
    return link + imm_sext[PC_W-1:0];
  endfunction

  // Region jump: keep the PC bits above the jump field, replace the rest
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] pc,
                                                  input logic [PC_W-1:0] ptgt);
    logic [PC_W-1:0] lo_mask;
    logic [PC_W-1:0] field;
    lo_mask = PC_W'({(TARGET_W+2){1'b1}});
    field   = PC_W'({ptgt[TARGET_W-1:0], 2'b00});
    return (pc & ~lo_mask) | field;
  endfunction

`ifdef CTRL_PERF_CNT_EN
  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction
`endif

  logic              advance;
  logic [PC_W-1:0]   link_p0;
  logic [PC_W-1:0]   tgt_p0;
  logic              d1_neg;
  logic              d1_zero;
  logic              br_taken;
  logic              jr_misalign;
  op_t               op_p0;
  op_t               pipe_p [STAGES];
  logic [STAGES-1:0] vld_p;

  // Single global advance: the whole pipe moves unless the output is held
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  // ---- stage 0: resolve the op combinationally from the offered inputs ----
  assign link_p0     = pc_i + PC_W'(8);
  assign tgt_p0      = branch_target(link_p0, immd_i);
  assign d1_neg      = data1_i[DATA_W-1];
  assign d1_zero     = (data1_i == '0);
  assign jr_misalign = (data1_i[1:0] != 2'b00);

  // Conditional-branch direction from the operand tests
  always_comb begin
    br_taken = 1'b0;
    case (opcode_i)
      OP_BEQ:  br_taken = (data1_i == data2_i);
      OP_BNE:  br_taken = (data1_i != data2_i);
      OP_BLEZ: br_taken = d1_neg || d1_zero;
      OP_BGTZ: br_taken = !d1_neg && !d1_zero;
      OP_BLTZ: br_taken = d1_neg;
      OP_BGEZ: br_taken = !d1_neg;
      default: br_taken = 1'b0;
    endcase
  end

  // Build the result record for the op; unrecognised opcodes carry only the tag
  always_comb begin
    op_p0     = '0;
    op_p0.tag = tag_i;
    case (opcode_i)
      OP_JUMP, OP_JAL: begin
        op_p0.next_pc        = jump_target(pc_i, predictedTarget_i);
        op_p0.flags[FL_CTRL] = 1'b1;
        op_p0.flags[FL_EXEC] = 1'b1;
        if (opcode_i == OP_JAL) begin
          op_p0.result         = link_p0;
          op_p0.flags[FL_LINK] = 1'b1;
        end
      end
      OP_JR, OP_JALR: begin
        op_p0.next_pc        = data1_i[PC_W-1:0];
        op_p0.flags[FL_CTRL] = 1'b1;
        op_p0.flags[FL_REGS] = 1'b1;
        op_p0.flags[FL_EXEC] = 1'b1;
        // A misaligned register target traps; the redirect comes from the
        // exception path, so it is never also reported as a mispredict.
        if (jr_misalign) begin
          op_p0.flags[FL_EXC] = 1'b1;
        end else begin
          op_p0.flags[FL_MISP] = (data1_i[PC_W-1:0] != predictedTarget_i);
        end
        if (opcode_i == OP_JALR) begin
          op_p0.result         = link_p0;
          op_p0.flags[FL_LINK] = 1'b1;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
        op_p0.direction      = br_taken;
        op_p0.next_pc        = br_taken ? tgt_p0 : link_p0;
        op_p0.flags[FL_CTRL] = 1'b1;
        op_p0.flags[FL_REGS] = 1'b1;
        op_p0.flags[FL_EXEC] = 1'b1;
        op_p0.flags[FL_MISP] = (br_taken != predictedDir_i);
      end
      OP_BC1F, OP_BC1T: begin
        // No FP condition unit behind this lane: always trap, fall through
        op_p0.next_pc        = link_p0;
        op_p0.flags[FL_CTRL] = 1'b1;
        op_p0.flags[FL_EXEC] = 1'b1;
        op_p0.flags[FL_EXC]  = 1'b1;
      end
      default: op_p0 = '{tag: tag_i, default: '0};
    endcase
  end

  // ---- stage boundary: valid bits shift on advance; flush/reset clear all ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (flush_i) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p[0] <= valid_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // ---- stage boundary: payload follows its valid bit; output record zeroed on reset ----
  always_ff @(posedge clk) begin
    if (advance) begin
      if (valid_i) begin
        pipe_p[0] <= op_p0;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (vld_p[i-1]) begin
          pipe_p[i] <= pipe_p[i-1];
        end
      end
    end
    if (reset) begin
      pipe_p[STAGES-1] <= '0;
    end
  end

  assign valid_o     = vld_p[STAGES-1];
  assign tag_o       = pipe_p[STAGES-1].tag;
  assign result_o    = pipe_p[STAGES-1].result;
  assign nextPC_o    = pipe_p[STAGES-1].next_pc;
  assign direction_o = pipe_p[STAGES-1].direction;
  assign flags_o     = pipe_p[STAGES-1].flags;

`ifdef CTRL_PERF_CNT_EN
  // Count delivered control ops and delivered mispredicts, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      brCount_o      <= '0;
      mispredCount_o <= '0;
    end else if (valid_o && ready_i) begin
      if (flags_o[FL_CTRL]) begin
        brCount_o <= sat_inc(brCount_o);
      end
      if (flags_o[FL_MISP]) begin
        mispredCount_o <= sat_inc(mispredCount_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_exec_pipe.sv
// tb_ctrl_exec_pipe: scoreboard bench for ctrl_exec_pipe (default parameters).
// Accepted ops are turned into expected records by a behavioural model and
// queued; an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps

module tb_ctrl_exec_pipe;

  localparam int STAGES = 2;

  localparam logic [7:0] OP_JUMP = 8'h01, OP_JAL  = 8'h02, OP_JR   = 8'h03, OP_JALR = 8'h04;
  localparam logic [7:0] OP_BEQ  = 8'h05, OP_BNE  = 8'h06, OP_BLEZ = 8'h07, OP_BGTZ = 8'h08;
  localparam logic [7:0] OP_BLTZ = 8'h09, OP_BGEZ = 8'h0A, OP_BC1F = 8'h0B, OP_BC1T = 8'h0C;

  logic        clk, reset, flush_i, valid_i, ready_o, predictedDir_i, valid_o, ready_i, direction_o;
  logic [31:0] data1_i, data2_i, predictedTarget_i, pc_i, result_o, nextPC_o;
  logic [15:0] immd_i;
  logic [7:0]  opcode_i, flags_o;
  logic [6:0]  tag_i, tag_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] br_cnt, mis_cnt;
`endif

  ctrl_exec_pipe #(.DATA_W(32), .PC_W(32), .IMM_W(16), .TARGET_W(26), .TAG_W(7),
                   .STAGES(STAGES), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .opcode_i(opcode_i),
    .predictedTarget_i(predictedTarget_i), .predictedDir_i(predictedDir_i), .pc_i(pc_i),
    .tag_i(tag_i), .tag_o(tag_o), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .nextPC_o(nextPC_o), .direction_o(direction_o), .flags_o(flags_o)
`ifdef CTRL_PERF_CNT_EN
    , .brCount_o(br_cnt), .mispredCount_o(mis_cnt)
`endif
  );

  typedef struct {
    logic [6:0]  tag;
    logic [31:0] result;
    logic [31:0] nextpc;
    logic        dir;
    logic [7:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   exp_br = 0, exp_mis = 0;
  bit   mon_en = 0, rand_rdy = 0;
  logic [6:0] tag_ctr = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference behaviour written from the architectural rules
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [15:0] imm, input logic [31:0] ptgt, input logic pdir,
                                 input logic [31:0] pc, input logic [6:0] tag);
    exp_t   e;
    longint off;
    logic [31:0] fall, taken_tgt;
    logic   cond;
    e.tag = tag; e.result = 0; e.nextpc = 0; e.dir = 0; e.flags = 0;
    off       = longint'($signed(imm)) * 4;
    fall      = 32'(longint'(pc) + 8);
    taken_tgt = 32'(longint'(pc) + 8 + off);
    cond      = 0;
    case (op)
      OP_BEQ:  cond = (d1 == d2);
      OP_BNE:  cond = (d1 != d2);
      OP_BLEZ: cond = ($signed(d1) <= 0);
      OP_BGTZ: cond = ($signed(d1) > 0);
      OP_BLTZ: cond = ($signed(d1) < 0);
      OP_BGEZ: cond = ($signed(d1) >= 0);
      default: cond = 0;
    endcase
    case (op)
      OP_JUMP, OP_JAL: begin
        e.nextpc = {pc[31:28], ptgt[25:0], 2'b00};
        e.flags  = (op == OP_JAL) ? 8'h8C : 8'h84;
        if (op == OP_JAL) e.result = fall;
      end
      OP_JR, OP_JALR: begin
        e.nextpc = d1;
        e.flags  = (op == OP_JALR) ? 8'hAC : 8'hA4;
        if (op == OP_JALR) e.result = fall;
        if (d1 % 4 != 0) e.flags = e.flags | 8'h02;
        else if (d1 != ptgt) e.flags = e.flags | 8'h01;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
        e.dir    = cond;
        e.nextpc = cond ? taken_tgt : fall;
        e.flags  = 8'hA4 | ((cond != pdir) ? 8'h01 : 8'h00);
      end
      OP_BC1F, OP_BC1T: begin
        e.nextpc = fall;
        e.flags  = 8'h86;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Stimulus side of the scoreboard: queue expectations for accepted ops
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && !flush_i && valid_i && ready_o)
        sb.push_back(model(opcode_i, data1_i, data2_i, immd_i, predictedTarget_i,
                           predictedDir_i, pc_i, tag_i));
    end
  end

  // Monitor: compare every delivered op, handshake rule and stall stability
  initial begin
    exp_t e;
    logic [63:0] snap_a, snap_b;
    bit snap_v;
    snap_v = 0; snap_a = 0; snap_b = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("ready_rule", ready_o, !valid_o || ready_i);
        if (snap_v) begin
          check("stall_ctl", {valid_o, direction_o, flags_o, tag_o}, snap_a);
          check("stall_data", {result_o, nextPC_o}, snap_b);
        end
        snap_v = valid_o && !ready_i && !reset && !flush_i;
        snap_a = {valid_o, direction_o, flags_o, tag_o};
        snap_b = {result_o, nextPC_o};
        if (reset) begin
          sb.delete();
          exp_br = 0; exp_mis = 0;
        end else begin
          if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL out_unexpected: got op tag 0x%0h want no output", tag_o);
            end else begin
              e = sb.pop_front();
              check("out_tag", tag_o, e.tag);
              check("out_result", result_o, e.result);
              check("out_nextpc", nextPC_o, e.nextpc);
              check("out_dir", direction_o, e.dir);
              check("out_flags", flags_o, e.flags);
              if (e.flags[7]) exp_br++;
              if (e.flags[0]) exp_mis++;
            end
          end
          if (flush_i) sb.delete();
        end
      end
    end
  end

  // Random back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] imm, input logic [31:0] ptgt, input logic pdir,
                       input logic [31:0] pc);
    valid_i = 1; opcode_i = op; data1_i = d1; data2_i = d2; immd_i = imm;
    predictedTarget_i = ptgt; predictedDir_i = pdir; pc_i = pc; tag_i = tag_ctr;
    tag_ctr++;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_o && !flush_i && !reset) break;
      n++;
      if (n > 200) begin
        n_vec++; n_err++;
        $display("FAIL accept_timeout: got ready_o low for %0d cycles want accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    valid_i = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] imm, input logic [31:0] ptgt, input logic pdir,
                       input logic [31:0] pc);
    drive(op, d1, d2, imm, ptgt, pdir, pc);
    wait_accept();
  endtask

  // Directed check of the just-accepted op against fixed expected values
  task automatic expect_out(input string nm, input logic [31:0] res, input logic [31:0] npc,
                            input logic dir, input logic [7:0] fl);
    int lat;
    lat = 1;
    while (!valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, STAGES);
    check({nm, "_result"}, result_o, res);
    check({nm, "_nextpc"}, nextPC_o, npc);
    check({nm, "_dir"}, direction_o, dir);
    check({nm, "_flags"}, flags_o, fl);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 0; ready_i = 1; valid_i = 0;
    while ((sb.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
    check("drain_valid_low", valid_o, 0);
  endtask

  task automatic rand_op();
    logic [7:0]  op;
    logic [31:0] d1, d2, pt, pc;
    op = 8'($urandom_range(0, 14));
    case ($urandom_range(0, 4))
      0: d1 = 0;
      1: d1 = $urandom_range(1, 20);
      2: d1 = 32'd0 - $urandom_range(1, 20);
      default: d1 = $urandom;
    endcase
    if ($urandom_range(0, 2) != 0) d1[1:0] = 2'b00;
    d2 = ($urandom_range(0, 2) == 0) ? d1 : $urandom;
    pt = ($urandom_range(0, 1) == 1) ? d1 : $urandom;
    pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 4 * $urandom_range(0, 3)) : ($urandom & ~32'h3);
    drive(op, d1, d2, 16'($urandom), pt, 1'($urandom_range(0, 1)), pc);
    wait_accept();
  endtask

  initial begin
    reset = 1; flush_i = 0; valid_i = 0; ready_i = 1;
    data1_i = 0; data2_i = 0; immd_i = 0; opcode_i = 0;
    predictedTarget_i = 0; predictedDir_i = 0; pc_i = 0; tag_i = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0; ready_i = 0;
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_tag_o", tag_o, 0);
    check("rst_result_o", result_o, 0);
    check("rst_nextpc_o", nextPC_o, 0);
    check("rst_flags_o", {direction_o, flags_o}, 0);
`ifdef CTRL_PERF_CNT_EN
    check("rst_counters", {br_cnt, mis_cnt}, 0);
`endif
    ready_i = 1;
    mon_en = 1;

    // Architectural examples
    issue(OP_BEQ, 5, 5, 16'h0004, 0, 0, 32'h100);
    expect_out("beq", 0, 32'h118, 1, 8'hA5);
    issue(OP_JALR, 32'h400, 0, 0, 32'h400, 0, 32'h200);
    expect_out("jalr", 32'h208, 32'h400, 0, 8'hAC);
    issue(OP_JALR, 32'h402, 0, 0, 32'h400, 0, 32'h200);
    expect_out("jalr_misalign", 32'h208, 32'h402, 0, 8'hAE);
    issue(OP_BNE, 1, 2, 16'hFFFF, 0, 1, 32'h10);
    expect_out("bne_back", 0, 32'h14, 1, 8'hA4);
    issue(OP_BNE, 3, 4, 16'h0000, 0, 1, 32'hFFFF_FFF8);
    expect_out("bne_wrap", 0, 32'h0, 1, 8'hA4);
    issue(OP_BC1T, 0, 0, 0, 0, 0, 32'h40);
    expect_out("bc1t", 0, 32'h48, 0, 8'h86);
    issue(8'h3F, 7, 7, 16'h1234, 32'h55, 1, 32'h80);
    expect_out("illegal", 0, 0, 0, 8'h00);

    // Back-pressure: fill the pipe, hold, then release
    ready_i = 0;
    issue(OP_BEQ, 9, 9, 16'h0010, 0, 1, 32'h1000);
    issue(OP_JAL, 0, 0, 0, 32'h0000_0ABC, 0, 32'h2000);
    drive(OP_BGEZ, 32'h8000_0000, 0, 16'h0002, 0, 0, 32'h3000);
    repeat (4) begin
      @(negedge clk);
      check("stall_ready_low", ready_o, 0);
    end
    @(posedge clk); #1;
    ready_i = 1;
    wait_accept();
    drain();

    // Flush with two ops in flight and one offered
    ready_i = 0;
    issue(OP_BLTZ, 32'hFFFF_FFFC, 0, 16'h0003, 0, 0, 32'h500);
    issue(OP_JR, 32'h600, 0, 0, 32'h604, 0, 32'h510);
    drive(OP_BGTZ, 1, 0, 16'h0001, 0, 1, 32'h520);
    flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0; valid_i = 0; ready_i = 1;
    repeat (2 * STAGES + 2) begin
      @(negedge clk);
      check("flush_no_valid", valid_o, 0);
    end
    @(posedge clk); #1;
    issue(OP_JUMP, 0, 0, 0, 32'h0001_2345, 0, 32'h3000_0010);
    expect_out("post_flush_jump", 0, 32'h3004_8D14, 0, 8'h84);

    // Randomised traffic with back-pressure, flushes and one reset
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (i == 200) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
      end else if (r < 3) begin
        drive(OP_BEQ, 1, 1, 16'h0001, 0, 0, 32'h700);
        valid_i = 1'($urandom_range(0, 1));
        flush_i = 1;
        @(posedge clk); #1;
        flush_i = 0; valid_i = 0;
      end else if (r < 20) begin
        @(posedge clk); #1;
      end else begin
        rand_op();
      end
    end
    drain();

`ifdef CTRL_PERF_CNT_EN
    check("cnt_br_random", br_cnt, exp_br);
    check("cnt_mis_random", mis_cnt, exp_mis);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 10; i++) issue(OP_BEQ, 4, 4, 16'h0001, 0, (i < 3) ? 1'b0 : 1'b1, 32'h900);
    drain();
    check("cnt_br_10", br_cnt, 10);
    check("cnt_mis_3", mis_cnt, 3);
`endif

    // Reset with ops in flight and the output stalled
    ready_i = 0;
    issue(OP_JAL, 0, 0, 0, 32'h10, 0, 32'h4000);
    issue(OP_BNE, 1, 2, 16'h0004, 0, 0, 32'h4010);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrst_valid_o", valid_o, 0);
    check("midrst_ready_o", ready_o, 1);
    check("midrst_nextpc_o", nextPC_o, 0);
    check("midrst_flags_o", flags_o, 0);
`ifdef CTRL_PERF_CNT_EN
    check("midrst_counters", {br_cnt, mis_cnt}, 0);
`endif
    ready_i = 1;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
